// File: rtl/vga_line_fetch.sv
// Ping-pong line fetcher feeding the 640x480 VGA timing generator from a 320x240 framebuffer.
// Optional colour-bar generator built when VGA_LINE_FETCH_TESTPAT_EN is defined.
module vga_line_fetch #(
  parameter int                ADDR_W         = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [11:0]       UNDERRUN_COLOR = 12'hF00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newline,
  input  logic              advance,
  input  logic [7:0]        line,
`ifdef VGA_LINE_FETCH_TESTPAT_EN
  input  logic              test_pattern,
`endif
  output logic [11:0]       pixel,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [11:0]       mem_rdata,
  output logic              underrun
);

  // state    | meaning
  // ST_IDLE  | no fetch in flight, back buffer either valid or waiting for a start decision
  // ST_FETCH | reading one row into the back buffer, one word per ack
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  logic [0:0]  state;
  logic        front_sel;
  logic        wr_sel;
  logic [7:0]  tag_f;
  logic [7:0]  tag_b;
  logic        fv;
  logic        bv;
  logic [7:0]  fetch_row;
  logic [8:0]  fetch_x;
  logic        line_vis;
  logic [9:0]  pix_k;
  logic [11:0] lbuf [0:1][0:319];

  logic        tp_active;
  logic        dec_start;
  logic [7:0]  dec_row;
  logic        dec_swap;
  logic        dec_fv_clr;
  logic        dec_under;
  logic        start_go;
  logic [ADDR_W-1:0] row_base;
  logic [9:0]  half;
  logic [8:0]  idx;
  logic [11:0] buf_pixel;

`ifdef VGA_LINE_FETCH_TESTPAT_EN
  assign tp_active = test_pattern;
`else
  assign tp_active = 1'b0;
`endif

  always_comb begin
    dec_start  = 1'b0;
    dec_row    = 8'd0;
    dec_swap   = 1'b0;
    dec_fv_clr = 1'b0;
    dec_under  = 1'b0;
    if (newline) begin
      if (line >= 8'd240) begin
        dec_fv_clr = 1'b1;
        if (!(bv && tag_b == 8'd0)) begin
          dec_start = 1'b1;
          dec_row   = 8'd0;
        end
      end else if (fv && tag_f == line) begin
        dec_start = 1'b0;
      end else if (bv && tag_b == line) begin
        dec_swap = 1'b1;
        if (line != 8'd239) begin
          dec_start = 1'b1;
          dec_row   = line + 8'd1;
        end
      end else begin
        dec_under  = 1'b1;
        dec_fv_clr = 1'b1;
        dec_start  = 1'b1;
        dec_row    = line;
      end
    end
  end

  assign start_go = dec_start && (state == ST_IDLE) && !tp_active;
  assign row_base = BASE_ADDR + (ADDR_W'(dec_row) << 8) + (ADDR_W'(dec_row) << 6);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= BASE_ADDR;
      underrun  <= 1'b0;
      front_sel <= 1'b0;
      wr_sel    <= 1'b1;
      tag_f     <= 8'd0;
      tag_b     <= 8'd0;
      fv        <= 1'b0;
      bv        <= 1'b0;
      fetch_row <= 8'd0;
      fetch_x   <= 9'd0;
      line_vis  <= 1'b0;
      pix_k     <= 10'd0;
    end else begin
      underrun <= dec_under && !tp_active;

      if (newline) begin
        line_vis <= (line < 8'd240);
        pix_k    <= 10'd0;
      end else if (advance && pix_k != 10'd1022) begin
        pix_k <= pix_k + 10'd1;
      end

      if (dec_fv_clr) fv <= 1'b0;
      // The old front becomes the back buffer and no longer holds a prefetched row.
      if (dec_swap) begin
        front_sel <= ~front_sel;
        tag_f     <= tag_b;
        fv        <= 1'b1;
        bv        <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state     <= ST_FETCH;
            mem_req   <= 1'b1;
            mem_addr  <= row_base;
            fetch_row <= dec_row;
            fetch_x   <= 9'd0;
            bv        <= 1'b0;
            wr_sel    <= dec_swap ? front_sel : ~front_sel;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            if (fetch_x == 9'd319) begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
              bv      <= 1'b1;
              tag_b   <= fetch_row;
            end else begin
              fetch_x  <= fetch_x + 9'd1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == ST_FETCH && mem_ack)
      lbuf[wr_sel][fetch_x] <= mem_rdata;
  end

  // Screen pixel k+1 maps to stored word (k+1)>>1, clamped to the last word.
  assign half      = (pix_k + 10'd1) >> 1;
  assign idx       = (half > 10'd319) ? 9'd319 : half[8:0];
  assign buf_pixel = lbuf[front_sel][idx];

`ifdef VGA_LINE_FETCH_TESTPAT_EN
  logic [9:0] scr;
  logic [2:0] bar;
  assign scr = advance ? (pix_k + 10'd1) : pix_k;
  assign bar = (scr >= 10'd560) ? 3'd7 : 3'(scr / 10'd80);

  always_comb begin
    if (test_pattern)
      pixel = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    else if (!line_vis)
      pixel = 12'h000;
    else if (!fv)
      pixel = UNDERRUN_COLOR;
    else
      pixel = buf_pixel;
  end
`else
  always_comb begin
    if (!line_vis)
      pixel = 12'h000;
    else if (!fv)
      pixel = UNDERRUN_COLOR;
    else
      pixel = buf_pixel;
  end
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: prefetch, swap, doubled rows, underrun, full frame, reset mid-fetch.
module tb_vga_line_fetch;
  localparam int ADDR_W = 17;
  localparam int BASE   = 1000;

  logic              clk;
  logic              rst_n;
  logic              newline;
  logic              advance;
  logic [7:0]        line;
  logic [11:0]       pixel;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [11:0]       mem_rdata;
  logic              underrun;

  logic [3:0]        ack_delay;
  logic [3:0]        wcnt = 4'd0;
  logic              late_ack;

  int errors = 0;
  int checks = 0;
  int req_starts = 0;
  int acks = 0;
  int ack_idx = 0;
  int addr_err = 0;
  int hold_err = 0;
  int under_cnt = 0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              prev_req = 1'b0;
  logic              prev_ack = 1'b0;

  vga_line_fetch #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(ADDR_W'(BASE)),
    .UNDERRUN_COLOR(12'hF00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .newline(newline),
    .advance(advance),
    .line(line),
    .pixel(pixel),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mem_data(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = (32'(a) * 32'd37) ^ (32'(a) >> 5);
    return t[11:0];
  endfunction

  function automatic logic [11:0] word(input int row, input int x);
    return mem_data(ADDR_W'(BASE + row * 320 + x));
  endfunction

  // Memory model: ack after ack_delay waiting cycles; late_ack forces a stray ack.
  assign mem_ack   = (mem_req === 1'b1 && wcnt == ack_delay) || late_ack;
  assign mem_rdata = mem_data(mem_addr);

  always @(posedge clk) begin
    if (mem_req !== 1'b1 || mem_ack) wcnt <= 4'd0;
    else wcnt <= wcnt + 4'd1;
  end

  always @(posedge clk) begin
    prev_req  <= (mem_req === 1'b1);
    prev_ack  <= (mem_req === 1'b1) && mem_ack;
    prev_addr <= mem_addr;
    if (underrun === 1'b1) under_cnt <= under_cnt + 1;
    if (mem_req === 1'b1 && !prev_req) req_starts <= req_starts + 1;
    if (mem_req === 1'b1 && prev_req && !prev_ack && mem_addr !== prev_addr) hold_err <= hold_err + 1;
    if (rst_n !== 1'b1) begin
      ack_idx <= 0;
    end else if (mem_req === 1'b1 && mem_ack) begin
      acks <= acks + 1;
      if (ack_idx == 0) first_addr <= mem_addr;
      else if (mem_addr !== first_addr + ADDR_W'(ack_idx)) addr_err <= addr_err + 1;
      ack_idx <= (ack_idx == 319) ? 0 : ack_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nl(input logic [7:0] l);
    line    = l;
    newline = 1'b1;
    tick();
    newline = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (mem_req === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check("idle_timeout", mem_req, 0);
  endtask

  // One 800-cycle scanline (newline tick already spent): 640 advance cycles then blanking.
  task automatic run_line(input int row, input bit under);
    logic [11:0] e;
    int          w;
    e = under ? 12'hF00 : word(row, 0);
    check("line_pix_start", pixel, e);
    for (int k = 0; k < 640; k++) begin
      advance = 1'b1;
      #1;
      w = ((k + 1) / 2 > 319) ? 319 : (k + 1) / 2;
      e = under ? 12'hF00 : word(row, w);
      check("line_pix", pixel, e);
      tick();
    end
    advance = 1'b0;
    repeat (159) tick();
  endtask

  initial begin
    int n, s0, a0, u0;
    rst_n = 1'b0; newline = 1'b0; advance = 1'b0; line = 8'd0;
    ack_delay = 4'd0; late_ack = 1'b0;
    repeat (3) tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_underrun", underrun, 0);
    check("rst_pixel", pixel, 0);
    rst_n = 1'b1;
    tick();

    // Blanking newline prefetches row 0.
    a0 = acks;
    nl(8'd245);
    check("s1_req", mem_req, 1);
    check("s1_addr0", mem_addr, BASE);
    wait_idle(n);
    check("s1_len", n, 320);
    check("s1_acks", acks - a0, 320);
    check("s1_first", first_addr, BASE);
    check("s1_order", addr_err, 0);
    check("s1_pixel_blank", pixel, 0);

    // Row 0 displayed, row 1 fetched behind it.
    u0 = under_cnt; s0 = req_starts;
    nl(8'd0);
    check("s2_req", mem_req, 1);
    check("s2_addr", mem_addr, BASE + 320);
    run_line(0, 1'b0);
    check("s2_underrun", under_cnt - u0, 0);
    check("s2_starts", req_starts - s0, 1);

    // Doubled row: no swap, no fetch.
    s0 = req_starts;
    nl(8'd0);
    run_line(0, 1'b0);
    check("s3_starts", req_starts - s0, 0);
    check("s3_req", mem_req, 0);

    // Slow memory: row 2 not ready when its line starts.
    ack_delay = 4'd6; a0 = acks; u0 = under_cnt;
    nl(8'd1);
    check("s4_addr", mem_addr, BASE + 640);
    run_line(1, 1'b0);
    nl(8'd1);
    run_line(1, 1'b0);
    nl(8'd2);
    check("s4_underrun", underrun, 1);
    check("s4_inflight", mem_req, 1);
    run_line(2, 1'b1);
    check("s4_pulses", under_cnt - u0, 1);
    check("s4_done", mem_req, 0);
    check("s4_acks", acks - a0, 320);
    check("s4_first", first_addr, BASE + 640);
    check("s4_order", addr_err, 0);
    check("s4_hold", hold_err, 0);
    ack_delay = 4'd0;
    nl(8'd2);
    check("s4_swap_pix", pixel, word(2, 0));
    check("s4_next_addr", mem_addr, BASE + 960);
    wait_idle(n);

    // Full frame of doubled rows, then blanking.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    s0 = req_starts; u0 = under_cnt;
    nl(8'd245);
    wait_idle(n);
    for (int l = 0; l < 240; l++) begin
      nl(8'(l));
      check("s5_pix0", pixel, word(l, 0));
      nl(8'(l));
      wait_idle(n);
    end
    check("s5_fetches", req_starts - s0, 240);
    check("s5_last", first_addr, BASE + 239 * 320);
    check("s5_idle_after_239", mem_req, 0);
    check("s5_underrun", under_cnt - u0, 0);
    check("s5_order", addr_err, 0);
    nl(8'd240);
    check("s5_prefetch_req", mem_req, 1);
    check("s5_prefetch_addr", mem_addr, BASE);

    // Reset while the row-0 prefetch is at x=100.
    n = 0;
    while (ack_idx != 100 && n < 500) begin
      tick();
      n++;
    end
    check("s6_reach_x100", ack_idx, 100);
    check("s6_addr_x100", mem_addr, BASE + 100);
    late_ack = 1'b1;
    rst_n = 1'b0;
    tick();
    check("s6_req_drop", mem_req, 0);
    check("s6_pixel", pixel, 0);
    check("s6_addr_rst", mem_addr, BASE);
    s0 = req_starts;
    rst_n = 1'b1;
    tick();
    tick();
    late_ack = 1'b0;
    check("s6_late_ack_ignored", mem_req, 0);
    check("s6_no_start", req_starts - s0, 0);
    a0 = acks;
    nl(8'd245);
    check("s6_req", mem_req, 1);
    check("s6_addr0", mem_addr, BASE);
    wait_idle(n);
    check("s6_len", n, 320);
    check("s6_acks", acks - a0, 320);
    check("s6_first", first_addr, BASE);
    check("s6_order", addr_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
